// File: rtl/mul_seq16.sv
// Iterative shift-add multiplier controller, WIDTH x WIDTH -> 2*WIDTH unsigned, driving an external adder.
// Optional build macro MUL_EARLY_TERM_EN: stop as soon as the remaining multiplier bits are zero.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready=1, waiting for start; operands captured on accept
// CALC  | one shift-add per cycle through the external adder
// DONE  | done pulse, product valid; returns to IDLE next cycle
module mul_seq16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 add_busy,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CNT_W-1:0]   cnt;

    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] acc_final;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               last_step;
    logic               start_zero;

    // Carry-out lands in the top bit; the consumed multiplier bit falls off the bottom.
    assign acc_step = {add_cout, add_sum, acc_lo[WIDTH-1:1]};
    assign cnt_nxt  = cnt + 1'b1;

`ifdef MUL_EARLY_TERM_EN
    logic [WIDTH-1:0] rem_mask;
    logic [CNT_W-1:0] rem_cnt;

    // After cnt_nxt shifts, the low WIDTH-cnt_nxt bits of acc_lo are still multiplier bits.
    assign rem_mask   = {WIDTH{1'b1}} >> cnt_nxt;
    assign rem_cnt    = CNT_W'(WIDTH) - cnt_nxt;
    assign last_step  = (acc_step[WIDTH-1:0] & rem_mask) == '0;
    assign acc_final  = acc_step >> rem_cnt;
    assign start_zero = (b == '0);
`else
    assign last_step  = (cnt == CNT_W'(WIDTH - 1));
    assign acc_final  = acc_step;
    assign start_zero = 1'b0;
`endif

    assign add_a   = add_busy ? acc_hi : '0;
    assign add_b   = (add_busy && acc_lo[0]) ? m : '0;
    assign add_cin = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            m        <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
            product  <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            add_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m      <= a;
                        acc_hi <= '0;
                        acc_lo <= b;
                        cnt    <= '0;
                        ready  <= 1'b0;
                        if (start_zero) begin
                            state   <= DONE;
                            product <= '0;
                            done    <= 1'b1;
                        end else begin
                            state    <= CALC;
                            add_busy <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt_nxt;
                    if (last_step) begin
                        {acc_hi, acc_lo} <= acc_final;
                        product          <= acc_final;
                        state            <= DONE;
                        done             <= 1'b1;
                        add_busy         <= 1'b0;
                    end else begin
                        {acc_hi, acc_lo} <= acc_step;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    ready    <= 1'b1;
                    add_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq16.sv
// Scoreboard bench for mul_seq16: directed operands, hand-computed products and done latencies.
// Build with MUL_EARLY_TERM_EN to check the early-termination latencies instead of the fixed ones.
module tb_mul_seq16;

`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        done;
    logic [31:0] product;
    logic        add_busy;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;

    mul_seq16 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .product  (product),
        .add_busy (add_busy),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Behavioural stand-in for the external 16-bit adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] prod;
        int          at_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic int steps(input int se);
        return EARLY ? se : 16;
    endfunction

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (product !== e.prod) begin
                        errors++;
                        $display("FAIL product: got %h expected %h (cycle %0d)", product, e.prod, cyc);
                    end
                    checks++;
                    if (cyc != e.at_cyc) begin
                        errors++;
                        $display("FAIL done_latency: got cycle %0d expected cycle %0d", cyc, e.at_cyc);
                    end
                end
            end else if (sb.size() > 0 && cyc > sb[0].at_cyc) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_done: got no done by cycle %0d expected at %0d", cyc, e.at_cyc);
            end
        end
    end

    // Called at a negedge; waits for ready, issues, returns one cycle after acceptance.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic [31:0] req, input int se, input bit hold);
        int n;
        exp_t e;
        n = 0;
        start = 1'b1;
        a = ta;
        b = tb_v;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 100 cycles");
        end
        e.prod   = req;
        e.at_cyc = cyc + 1 + steps(se);
        sb.push_back(e);
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk("ready_after_accept", {31'd0, ready}, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_product", product, 32'd0);
        chk("rst_add_busy", {31'd0, add_busy}, 32'd0);
        chk("rst_add_a", {16'd0, add_a}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic op, with a start pulse during CALC that must be ignored.
        issue(16'd3, 16'd5, 32'h0000_000F, 3, 1'b0);
        chk("calc_add_busy", {31'd0, add_busy}, 32'd1);
        start = 1'b1;
        a = 16'd7;
        b = 16'd7;
        @(negedge clk);
        start = 1'b0;
        drain();
        chk("product_held", product, 32'h0000_000F);
        chk("idle_add_b", {16'd0, add_b}, 32'd0);
        chk("idle_add_cin", {31'd0, add_cin}, 32'd0);

        issue(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16, 1'b0);
        drain();
        issue(16'h1234, 16'h0003, 32'h0000_369C, 2, 1'b0);
        drain();
        issue(16'h1234, 16'h0000, 32'h0000_0000, 0, 1'b0);
        drain();
        issue(16'hABCD, 16'h0001, 32'h0000_ABCD, 1, 1'b0);
        drain();
        issue(16'h8000, 16'h8000, 32'h4000_0000, 16, 1'b0);
        drain();
        issue(16'h00FF, 16'h0100, 32'h0000_FF00, 9, 1'b0);
        drain();
        issue(16'h1234, 16'h5678, 32'h0626_0060, 15, 1'b0);
        drain();

        // Reset in the middle of a long op aborts it.
        issue(16'h00FF, 16'h8001, 32'h0000_0000, 16, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_product", product, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        issue(16'd2, 16'd2, 32'h0000_0004, 2, 1'b0);
        drain();

        // Back-to-back with start held high throughout.
        issue(16'h0011, 16'h0101, 32'h0000_1111, 9, 1'b1);
        issue(16'h0100, 16'h00F0, 32'h0000_F000, 8, 1'b1);
        chk("b2b_product_holds", product, 32'h0000_1111);
        issue(16'hFFFF, 16'h0002, 32'h0001_FFFE, 2, 1'b0);
        drain();
        chk("final_product", product, 32'h0001_FFFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
